// File: rtl/pid_sweep_scheduler.sv
// Shares one PID unit across NUM_CH motor channels, one sweep per control tick.
// Ports: clk/reset, enable, err_in/limit_in, pid_req_*/pid_rsp_*, corr_out, status.
module pid_sweep_scheduler #(
  parameter int                 NUM_CH      = 8,
  parameter int                 TICK_DIV    = 50000,
  parameter logic signed [31:0] CORR_LIM    = 32'sd1000000,
  parameter int                 RSP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_CH*32-1:0]  err_in,
  input  logic [NUM_CH-1:0]     limit_in,
  output logic                  pid_req_valid,
  input  logic                  pid_req_ready,
  output logic [3:0]            pid_req_ch,
  output logic [31:0]           pid_req_err,
  input  logic                  pid_rsp_valid,
  input  logic [31:0]           pid_rsp_corr,
  output logic [NUM_CH*32-1:0]  corr_out,
  output logic                  sweep_done,
  output logic                  busy,
  output logic [15:0]           overrun_cnt,
  output logic [NUM_CH-1:0]     timeout_flags
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);
  localparam logic [15:0]   W_LAST = 16'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_PUBLISH
  } state_t;

  state_t             state, state_nx;
  logic [TW-1:0]      tcnt;
  logic               tick;
  logic [CW-1:0]      ch;
  logic               req_pend;
  logic               skip;
  logic [15:0]        wcnt;
  logic signed [31:0] clamped;
  logic signed [31:0] snap   [NUM_CH];
  logic signed [31:0] shadow [NUM_CH];

  assign tick        = enable && (tcnt == T_LAST);
  assign busy        = (state != S_IDLE);
  assign pid_req_ch  = 4'(ch);
  assign pid_req_err = snap[ch];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Once a request is raised it stays up until accepted, even if the
  // limit switch closes in the meantime (req_pend masks the skip).
  always_comb begin
    state_nx      = state;
    pid_req_valid = 1'b0;
    skip          = 1'b0;
    unique case (state)
      S_IDLE: if (tick) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (!req_pend && limit_in[ch]) begin
          skip     = 1'b1;
          state_nx = S_STORE;
        end else begin
          pid_req_valid = 1'b1;
          if (pid_req_ready) state_nx = S_WAIT;
        end
      end
      S_WAIT:
        if (pid_rsp_valid || wcnt == W_LAST) state_nx = S_STORE;
      S_STORE:
        state_nx = (ch == C_LAST) ? S_PUBLISH : S_ISSUE;
      S_PUBLISH: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    clamped = pid_rsp_corr;
    if ($signed(pid_rsp_corr) > CORR_LIM)       clamped = CORR_LIM;
    else if ($signed(pid_rsp_corr) < -CORR_LIM) clamped = -CORR_LIM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt          <= '0;
      ch            <= '0;
      req_pend      <= 1'b0;
      wcnt          <= '0;
      overrun_cnt   <= '0;
      timeout_flags <= '0;
      corr_out      <= '0;
      sweep_done    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        snap[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      sweep_done <= 1'b0;
      if (!enable || tcnt == T_LAST) tcnt <= '0;
      else                           tcnt <= tcnt + TW'(1);
      if (tick && busy && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (tick) begin
            for (int k = 0; k < NUM_CH; k++)
              snap[k] <= err_in[32*k +: 32];
            ch <= '0;
          end
        end
        S_ISSUE: begin
          wcnt <= '0;
          if (skip) shadow[ch] <= '0;
          else      req_pend   <= !pid_req_ready;
        end
        S_WAIT: begin
          if (pid_rsp_valid) begin
            shadow[ch] <= clamped;
          end else if (wcnt == W_LAST) begin
            shadow[ch]        <= '0;
            timeout_flags[ch] <= 1'b1;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_STORE: if (ch != C_LAST) ch <= ch + CW'(1);
        S_PUBLISH: begin
          for (int k = 0; k < NUM_CH; k++)
            corr_out[32*k +: 32] <= shadow[k];
          sweep_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_sweep_scheduler.sv
// Directed bench for pid_sweep_scheduler: vector table of sweeps plus
// hand sequences for timing, enable drop, request hold and mid-sweep reset.
module tb_pid_sweep_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [255:0] err_in;
  logic [7:0]   limit_in;
  logic         pid_req_valid;
  logic         pid_req_ready;
  logic [3:0]   pid_req_ch;
  logic [31:0]  pid_req_err;
  logic         pid_rsp_valid = 1'b0;
  logic [31:0]  pid_rsp_corr = '0;
  logic [255:0] corr_out;
  logic         sweep_done;
  logic         busy;
  logic [15:0]  overrun_cnt;
  logic [7:0]   timeout_flags;

  pid_sweep_scheduler #(
    .NUM_CH(8), .TICK_DIV(64), .RSP_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .err_in(err_in), .limit_in(limit_in),
    .pid_req_valid(pid_req_valid), .pid_req_ready(pid_req_ready),
    .pid_req_ch(pid_req_ch), .pid_req_err(pid_req_err),
    .pid_rsp_valid(pid_rsp_valid), .pid_rsp_corr(pid_rsp_corr),
    .corr_out(corr_out), .sweep_done(sweep_done), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_flags(timeout_flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int       mode = 0;
  int       lat = 3;
  logic [7:0] nores = '0;
  int       sweep_id = 0;
  int       last_req [8];

  bit                 pend = 0;
  int                 dly = 0;
  logic signed [31:0] rval = '0;

  function automatic logic signed [31:0] model_corr(
    input int m, input logic [3:0] c, input logic [31:0] e);
    logic signed [31:0] r;
    r = $signed(e) * 2;
    if (m == 1) begin
      if (c == 4'd1) r = 32'sd2000000;
      if (c == 4'd2) r = -32'sd5000000;
    end else if (m == 2) begin
      if (c == 4'd1) r = 32'sd1000000;
      if (c == 4'd2) r = -32'sd1000001;
      if (c == 4'd3) r = 32'sd1000001;
    end
    return r;
  endfunction

  // PID unit model: responds L cycles after the accepting edge
  always @(negedge clk) begin
    pid_rsp_valid = 1'b0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        dly--;
        if (dly == 0) begin
          pid_rsp_valid = 1'b1;
          pid_rsp_corr  = rval;
          pend          = 0;
        end
      end
      if (pid_req_valid && pid_req_ready && !nores[pid_req_ch[2:0]]) begin
        pend = 1;
        dly  = lat;
        rval = model_corr(mode, pid_req_ch, pid_req_err);
      end
    end
  end

  initial for (int k = 0; k < 8; k++) last_req[k] = -1;

  always @(posedge clk)
    if (pid_req_valid && pid_req_ready)
      last_req[pid_req_ch[2:0]] = sweep_id;

  function automatic logic [7:0] req_mask();
    logic [7:0] m;
    for (int k = 0; k < 8; k++) m[k] = (last_req[k] == sweep_id);
    return m;
  endfunction

  function automatic logic [255:0] pk(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    logic [255:0] r;
    r[31:0]    = a0; r[63:32]   = a1;
    r[95:64]   = a2; r[127:96]  = a3;
    r[159:128] = a4; r[191:160] = a5;
    r[223:192] = a6; r[255:224] = a7;
    return r;
  endfunction

  task automatic set_err(input int base);
    for (int k = 0; k < 8; k++) err_in[32*k +: 32] = base * k;
  endtask

  task automatic chk(input string nm,
                     input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic count_to_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (busy) return;
    end
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (sweep_done) begin ok = 1; return; end
    end
  endtask

  typedef struct packed {
    int           base;
    logic [7:0]   limit;
    logic [7:0]   nores;
    int           mode;
    int           lat;
    logic [255:0] corr;
    logic [7:0]   flags;
    logic [15:0]  ovr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    bit ok;

    tbl[0] = '{base:100, limit:8'h00, nores:8'h00, mode:0, lat:3,
      corr:pk(0,200,400,600,800,1000,1200,1400), flags:8'h00, ovr:16'd0};
    tbl[1] = '{base:100, limit:8'h00, nores:8'h00, mode:1, lat:3,
      corr:pk(0,1000000,-1000000,600,800,1000,1200,1400),
      flags:8'h00, ovr:16'd0};
    tbl[2] = '{base:100, limit:8'h04, nores:8'h00, mode:0, lat:3,
      corr:pk(0,200,0,600,800,1000,1200,1400), flags:8'h00, ovr:16'd0};
    tbl[3] = '{base:100, limit:8'h00, nores:8'h20, mode:0, lat:3,
      corr:pk(0,200,400,600,800,0,1200,1400), flags:8'h20, ovr:16'd4};
    tbl[4] = '{base:-50, limit:8'h00, nores:8'h00, mode:0, lat:3,
      corr:pk(0,-100,-200,-300,-400,-500,-600,-700),
      flags:8'h20, ovr:16'd4};
    tbl[5] = '{base:100, limit:8'h00, nores:8'h00, mode:2, lat:3,
      corr:pk(0,1000000,-1000000,1000000,800,1000,1200,1400),
      flags:8'h20, ovr:16'd4};
    tbl[6] = '{base:7, limit:8'h00, nores:8'h00, mode:0, lat:10,
      corr:pk(0,14,28,42,56,70,84,98), flags:8'h20, ovr:16'd5};

    reset = 1'b1;
    enable = 1'b1;
    pid_req_ready = 1'b1;
    limit_in = '0;
    set_err(100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_corr", corr_out, '0);
    chk("rst_busy", {255'd0, busy}, '0);
    chk("rst_valid", {255'd0, pid_req_valid}, '0);
    chk("rst_done", {255'd0, sweep_done}, '0);
    chk("rst_ovr", {240'd0, overrun_cnt}, '0);
    chk("rst_flags", {248'd0, timeout_flags}, '0);

    reset = 1'b0;
    count_to_busy(n);
    chk("first_start", n, 64);
    m = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      m++;
    end
    chk("sweep_len", m, 41);
    chk("done_pulse", {255'd0, sweep_done}, 256'd1);
    chk("corr_first", corr_out, tbl[0].corr);
    chk("ovr_first", {240'd0, overrun_cnt}, '0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (sweep_done) break;
    end
    chk("period", n, 64);

    for (int v = 0; v < 7; v++) begin
      set_err(tbl[v].base);
      limit_in = tbl[v].limit;
      nores    = tbl[v].nores;
      mode     = tbl[v].mode;
      lat      = tbl[v].lat;
      sweep_id = sweep_id + 1;
      wait_done(1000, ok);
      chk($sformatf("v%0d_done", v), {255'd0, ok}, 256'd1);
      chk($sformatf("v%0d_corr", v), corr_out, tbl[v].corr);
      chk($sformatf("v%0d_flags", v), {248'd0, timeout_flags},
          {248'd0, tbl[v].flags});
      chk($sformatf("v%0d_ovr", v), {240'd0, overrun_cnt},
          {240'd0, tbl[v].ovr});
      chk($sformatf("v%0d_reqs", v), {248'd0, req_mask()},
          {248'd0, ~tbl[v].limit});
    end

    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy) begin ok = 1; break; end
    end
    chk("en_busy", {255'd0, ok}, 256'd1);
    enable = 1'b0;
    wait_done(300, ok);
    chk("en_finish", {255'd0, ok}, 256'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    chk("en_idle", n, 0);
    chk("en_ovr", {240'd0, overrun_cnt}, 256'd5);

    pid_req_ready = 1'b0;
    lat = 3;
    set_err(100);
    err_in[31:0] = 32'd777;
    enable = 1'b1;
    count_to_busy(n);
    chk("reen_start", n, 64);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {255'd0, pid_req_valid}, 256'd1);
      chk("hold_ch", {252'd0, pid_req_ch}, '0);
      chk("hold_err", {224'd0, pid_req_err}, 256'd777);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_hs_valid", {255'd0, pid_req_valid}, '0);
    chk("rst_hs_busy", {255'd0, busy}, '0);
    chk("rst_hs_flags", {248'd0, timeout_flags}, '0);
    chk("rst_hs_ovr", {240'd0, overrun_cnt}, '0);
    pid_req_ready = 1'b1;
    reset = 1'b0;
    count_to_busy(n);
    chk("rst_hs_start", n, 64);

    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy && !pid_req_valid && pid_req_ch == 4'd3) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_ch3", {255'd0, ok}, 256'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_w_valid", {255'd0, pid_req_valid}, '0);
    chk("rst_w_busy", {255'd0, busy}, '0);
    chk("rst_w_corr", corr_out, '0);
    reset = 1'b0;
    count_to_busy(n);
    chk("rst_w_start", n, 64);
    wait_done(100, ok);
    chk("rst_w_done", {255'd0, ok}, 256'd1);
    chk("rst_w_frame", corr_out,
        pk(1554,200,400,600,800,1000,1200,1400));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
